// File: rtl/nanosoc_ahb_pkg.sv
// Shared AHB encodings and arbiter mode constants for the nanosoc bus matrix.
package nanosoc_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Remaining beats after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    logic [3:0] beats;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                      beats = 4'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/nanosoc_arb_burst_tracker.sv
// Tracks the burst on the output port: beat counter, burst hold,
// early-termination counter and the undefined-length INCR beat cap.
module nanosoc_arb_burst_tracker
  import nanosoc_ahb_pkg::*;
#(
  parameter int MAX_EARLY_TERM = 2,
  parameter int INCR_MAX_BEATS = 0
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  output logic       next_hold,
  output logic       early_term_sat,
  output logic       incr_expired
);

  localparam logic [1:0] ETC_MAX  = 2'(MAX_EARLY_TERM);
  localparam logic [7:0] INCR_CAP = 8'(INCR_MAX_BEATS);

  logic [3:0] burst_count_q, burst_count_d;
  logic       burst_hold_q, burst_hold_d;
  logic [1:0] early_term_count_q, early_term_count_d;
  logic       early_term_sat_q, early_term_sat_d;
  logic [7:0] incr_count_q, incr_count_d;

  always_comb begin
    burst_count_d = burst_count_q;
    burst_hold_d  = burst_hold_q;
    if (!HSELM) begin
      burst_count_d = 4'd0;
      burst_hold_d  = 1'b0;
    end else begin
      case (HTRANSM)
        HTRANS_NONSEQ: begin
          // Too many restarts in a row: stop protecting this master's bursts.
          if (early_term_count_q == ETC_MAX) begin
            burst_count_d = 4'd0;
            burst_hold_d  = 1'b0;
          end else begin
            burst_count_d = burst_beats_m1(HBURSTM);
            burst_hold_d  = (burst_beats_m1(HBURSTM) != 4'd0);
          end
        end
        HTRANS_SEQ: begin
          if (burst_count_q != 4'd0) burst_count_d = burst_count_q - 4'd1;
          if (burst_count_q == 4'd1) burst_hold_d = 1'b0;
        end
        HTRANS_BUSY: begin
        end
        default: begin
          burst_count_d = 4'd0;
          burst_hold_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    early_term_count_d = early_term_count_q;
    if (!burst_hold_d) begin
      early_term_count_d = 2'd0;
    end else if (burst_hold_q && (HTRANSM == HTRANS_NONSEQ) &&
                 (early_term_count_q != ETC_MAX)) begin
      early_term_count_d = early_term_count_q + 2'd1;
    end
    early_term_sat_d = (early_term_count_d == ETC_MAX);
  end

  always_comb begin
    incr_count_d = 8'd0;
    if ((INCR_MAX_BEATS != 0) && (HBURSTM == HBURST_INCR)) begin
      if (HTRANSM == HTRANS_NONSEQ) begin
        incr_count_d = 8'd1;
      end else if (HTRANSM == HTRANS_SEQ) begin
        incr_count_d = (incr_count_q == INCR_CAP) ? incr_count_q : incr_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      burst_count_q      <= 4'd0;
      burst_hold_q       <= 1'b0;
      early_term_count_q <= 2'd0;
      early_term_sat_q   <= 1'b0;
      incr_count_q       <= 8'd0;
    end else if (HREADYM) begin
      burst_count_q      <= burst_count_d;
      burst_hold_q       <= burst_hold_d;
      early_term_count_q <= early_term_count_d;
      early_term_sat_q   <= early_term_sat_d;
      incr_count_q       <= incr_count_d;
    end
  end

  assign next_hold      = burst_hold_d;
  assign early_term_sat = early_term_sat_q;
  assign incr_expired   = (INCR_MAX_BEATS != 0) && (incr_count_q == INCR_CAP);

endmodule

// File: rtl/nanosoc_arbiter_param.sv
// Output-stage arbiter for one slave port of the nanosoc AHB bus matrix:
// picks which of NUM_PORTS input stages drives the slave, fixed-priority or round-robin.
module nanosoc_arbiter_param
  import nanosoc_ahb_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int ARB_MODE       = ARB_FIXED,
  parameter int MAX_EARLY_TERM = 2,
  parameter int INCR_MAX_BEATS = 0,
  localparam int PORT_W        = $clog2(NUM_PORTS)
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 early_term_sat
);

  logic [PORT_W-1:0]    addr_q, addr_d;
  logic [PORT_W-1:0]    rr_last_q, rr_last_d;
  logic                 no_port_q, no_port_d;
  logic                 next_hold, incr_expired, cont;
  logic [NUM_PORTS-1:0] cur_onehot, eff_req;
  logic [PORT_W-1:0]    winner;

  function automatic logic [PORT_W-1:0] pick_fixed(input logic [NUM_PORTS-1:0] req);
    logic [PORT_W-1:0] sel;
    sel = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[PORT_W'(i)]) sel = PORT_W'(i);
    end
    return sel;
  endfunction

  // Scan starts just after the last round-robin winner and wraps back to it.
  function automatic logic [PORT_W-1:0] pick_rr(input logic [NUM_PORTS-1:0] req,
                                                input logic [PORT_W-1:0]    last);
    logic [PORT_W-1:0] sel;
    logic              hit;
    int                idx;
    sel = '0;
    hit = 1'b0;
    idx = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last) + k) % NUM_PORTS;
      if (!hit && req[PORT_W'(idx)]) begin
        sel = PORT_W'(idx);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  nanosoc_arb_burst_tracker #(
    .MAX_EARLY_TERM (MAX_EARLY_TERM),
    .INCR_MAX_BEATS (INCR_MAX_BEATS)
  ) u_tracker (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .HREADYM        (HREADYM),
    .HSELM          (HSELM),
    .HTRANSM        (HTRANSM),
    .HBURSTM        (HBURSTM),
    .next_hold      (next_hold),
    .early_term_sat (early_term_sat),
    .incr_expired   (incr_expired)
  );

  // The active master keeps an implicit request while its transfer continues.
  always_comb begin
    cur_onehot         = '0;
    cur_onehot[addr_q] = 1'b1;
    cont               = HSELM && (HTRANSM != HTRANS_IDLE) && !incr_expired;
    eff_req            = req_port | (cont ? cur_onehot : '0);
    winner             = (ARB_MODE == ARB_RR) ? pick_rr(eff_req, rr_last_q) : pick_fixed(eff_req);
  end

  always_comb begin
    addr_d    = addr_q;
    no_port_d = no_port_q;
    rr_last_d = rr_last_q;
    if (HMASTLOCKM || next_hold) begin
      no_port_d = 1'b0;
    end else if (eff_req != '0) begin
      addr_d    = winner;
      no_port_d = 1'b0;
      // A continuation-only re-win does not advance the round-robin pointer.
      if ((ARB_MODE == ARB_RR) && ((winner != addr_q) || req_port[addr_q])) begin
        rr_last_d = winner;
      end
    end else if (HSELM) begin
      no_port_d = 1'b0;
    end else begin
      no_port_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q    <= '0;
      no_port_q <= 1'b1;
      rr_last_q <= PORT_W'(NUM_PORTS - 1);
    end else if (HREADYM) begin
      addr_q    <= addr_d;
      no_port_q <= no_port_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign addr_in_port = addr_q;
  assign no_port      = no_port_q;

endmodule

// File: tb/tb_nanosoc_arbiter_param.sv
// Bench for nanosoc_arbiter_param: one fixed-priority instance and one round-robin
// instance share stimulus; each vector names which instance it checks.
module tb_nanosoc_arbiter_param;
  import nanosoc_ahb_pkg::*;

  typedef struct {
    bit       rr;
    bit       rst, rdy, sel;
    bit [1:0] tr;
    bit [2:0] bu;
    bit       lk;
    bit [3:0] rq;
    bit [1:0] e_port;
    bit       e_nop, e_sat;
  } vec_t;

  typedef struct {
    int       idx;
    bit       rr;
    bit [1:0] port;
    bit       nop, sat;
  } exp_t;

  logic       HCLK = 1'b0;
  logic       HRESET, HREADYM, HSELM, HMASTLOCKM;
  logic [3:0] req_port;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic [1:0] port_f, port_r;
  logic       nop_f, nop_r, sat_f, sat_r;

  vec_t vecs[$];
  exp_t expq[$];
  int   ncmp = 0;
  int   nerr = 0;

  always #5 HCLK = ~HCLK;

  nanosoc_arbiter_param #(
    .NUM_PORTS(4), .ARB_MODE(ARB_FIXED), .MAX_EARLY_TERM(2), .INCR_MAX_BEATS(4)
  ) dut_f (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(port_f), .no_port(nop_f), .early_term_sat(sat_f)
  );

  nanosoc_arbiter_param #(
    .NUM_PORTS(4), .ARB_MODE(ARB_RR), .MAX_EARLY_TERM(2), .INCR_MAX_BEATS(0)
  ) dut_r (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(port_r), .no_port(nop_r), .early_term_sat(sat_r)
  );

  function automatic vec_t mk(bit rr, bit rst, bit rdy, bit sel, bit [1:0] tr, bit [2:0] bu,
                              bit lk, bit [3:0] rq, bit [1:0] ep, bit en, bit es);
    vec_t v;
    v.rr = rr; v.rst = rst; v.rdy = rdy; v.sel = sel; v.tr = tr; v.bu = bu;
    v.lk = lk; v.rq = rq; v.e_port = ep; v.e_nop = en; v.e_sat = es;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s vec %0d: got %0d, want %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d", ncmp);
    $fatal(1, "watchdog");
  end

  initial begin
    localparam bit [1:0] I = HTRANS_IDLE, N = HTRANS_NONSEQ, S = HTRANS_SEQ;
    localparam bit [2:0] SG = HBURST_SINGLE, IN = HBURST_INCR, I4 = HBURST_INCR4;
    localparam bit [2:0] I8 = HBURST_INCR8, I16 = HBURST_INCR16;
    exp_t e;

    //                rr rst rdy sel tr  bu  lk req      port nop sat
    // reset then idle, HREADYM toggling, then selected-but-idle
    vecs.push_back(mk(0, 1, 1, 0, I, SG, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, I, SG, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, I, SG, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, I, SG, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, I, SG, 0, 4'b0000, 0, 0, 0));
    // fixed-priority lock-out: port 2 INCR8, port 0 requests from beat 2
    vecs.push_back(mk(0, 1, 1, 0, I, SG, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, I, SG, 0, 4'b0100, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, N, I8, 0, 4'b0100, 2, 0, 0));
    for (int b = 2; b <= 7; b++)
      vecs.push_back(mk(0, 0, 1, 1, S, I8, 0, 4'b0101, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, S, I8, 0, 4'b0101, 0, 0, 0));
    // round-robin: continuation-only win keeps pointer, then 0,1,2,3,0, stall
    vecs.push_back(mk(1, 1, 1, 0, I, SG, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, N, SG, 0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, N, SG, 0, 4'b1111, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, N, SG, 0, 4'b1111, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, N, SG, 0, 4'b1111, 2, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, N, SG, 0, 4'b1111, 3, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, N, SG, 0, 4'b1111, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, N, SG, 0, 4'b1111, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, N, SG, 0, 4'b1111, 1, 0, 0));
    // early termination: port 1 restarts INCR4 after one beat, port 0 waiting
    vecs.push_back(mk(0, 1, 1, 0, I, SG, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, I, SG, 0, 4'b0010, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, N, I4, 0, 4'b0011, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, S, I4, 0, 4'b0011, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, N, I4, 0, 4'b0011, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, S, I4, 0, 4'b0011, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, N, I4, 0, 4'b0011, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, S, I4, 0, 4'b0011, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, N, I4, 0, 4'b0011, 0, 0, 0));
    // INCR cap of 4 beats: port 1 holds via continuation, port 3 waiting
    vecs.push_back(mk(0, 1, 1, 0, I, SG, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, I, SG, 0, 4'b0010, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, N, IN, 0, 4'b1000, 1, 0, 0));
    for (int b = 2; b <= 4; b++)
      vecs.push_back(mk(0, 0, 1, 1, S, IN, 0, 4'b1000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, S, IN, 0, 4'b1000, 3, 0, 0));
    // same with lock: never broken
    vecs.push_back(mk(0, 1, 1, 0, I, SG, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, I, SG, 0, 4'b0010, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, N, IN, 1, 4'b1000, 1, 0, 0));
    for (int b = 2; b <= 6; b++)
      vecs.push_back(mk(0, 0, 1, 1, S, IN, 1, 4'b1000, 1, 0, 0));
    // stall freezes a held INCR16, then reset mid-burst
    vecs.push_back(mk(0, 1, 1, 0, I, SG, 0, 4'b0000, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, I, SG, 0, 4'b0100, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, N, I16, 0, 4'b0100, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, S, I16, 0, 4'b0001, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, S, I16, 0, 4'b0001, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, I, SG, 0, 4'b0000, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, S, I16, 0, 4'b0001, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, S, I16, 0, 4'b0001, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, S, I16, 0, 4'b0001, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge HCLK);
      HRESET     = vecs[i].rst;
      HREADYM    = vecs[i].rdy;
      HSELM      = vecs[i].sel;
      HTRANSM    = vecs[i].tr;
      HBURSTM    = vecs[i].bu;
      HMASTLOCKM = vecs[i].lk;
      req_port   = vecs[i].rq;
      e.idx = i; e.rr = vecs[i].rr; e.port = vecs[i].e_port;
      e.nop = vecs[i].e_nop; e.sat = vecs[i].e_sat;
      expq.push_back(e);
      @(posedge HCLK);
      #1;
      if (expq.size() == 0) begin
        check("scoreboard_empty", i, 0, 1);
      end else begin
        e = expq.pop_front();
        check("addr_in_port", e.idx, e.rr ? int'(port_r) : int'(port_f), int'(e.port));
        check("no_port", e.idx, e.rr ? int'(nop_r) : int'(nop_f), int'(e.nop));
        check("early_term_sat", e.idx, e.rr ? int'(sat_r) : int'(sat_f), int'(e.sat));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
